// File: rtl/filter_pkg.sv
// Shared types and constants for the synthetic video pattern source.
package filter_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pat_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H_ACTIVE   = 64;
  localparam int DEF_H_FP       = 4;
  localparam int DEF_H_SYNC     = 4;
  localparam int DEF_H_BP       = 8;
  localparam int DEF_V_ACTIVE   = 48;
  localparam int DEF_V_FP       = 2;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 2;

  // Luma of the eight colour bars, left to right, for 8-bit components.
  localparam logic [7:0] BAR_Y [8] = '{8'd235, 8'd210, 8'd170, 8'd145,
                                       8'd106, 8'd81,  8'd41,  8'd16};

  // Counters are at least 4 bits so the checkerboard can always use bit 3.
  function automatic int cnt_width(input int n);
    return (n <= 16) ? 4 : $clog2(n);
  endfunction

endpackage

// File: rtl/filter_hv_counter.sv
// Raster position counters: h sweeps each line, v advances on every h wrap.
module filter_hv_counter
  import filter_pkg::*;
#(
  parameter int H_TOTAL = 80,
  parameter int V_TOTAL = 54,
  localparam int HW = cnt_width(H_TOTAL),
  localparam int VW = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_h_last,
  output logic          o_v_last,
  output logic          o_frame_last
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  assign o_h          = h_q;
  assign o_v          = v_q;
  assign o_h_last     = (int'(h_q) == H_TOTAL - 1);
  assign o_v_last     = (int'(v_q) == V_TOTAL - 1);
  assign o_frame_last = o_h_last && o_v_last;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_adv) begin
      if (o_h_last) begin
        h_d = '0;
        v_d = o_v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/filter_pattern_gen.sv
// Raster timing and YUV test-pattern source feeding the 5x5 filter input.
module filter_pattern_gen
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [1:0]            i_pat_sel,
  input  logic [DATA_WIDTH-1:0] i_solid_y,
  input  logic [DATA_WIDTH-1:0] i_solid_u,
  input  logic [DATA_WIDTH-1:0] i_solid_v,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_u,
  output logic [DATA_WIDTH-1:0] o_v,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W < 2) ? 1 : $clog2(BAR_W);
  localparam int PW      = 4 + 3 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  gen_state_e    state_q, state_d;
  pat_sel_e      pat_q, pat_d, pat_eff;
  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [PW-1:0] s1_q, s1_d;
  logic [PW-1:0] out_q;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, frame_last;
  logic          active;

  assign active = (state_q != ST_IDLE);

  filter_hv_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_hv (
    .clk         (clk),
    .rst         (rst),
    .i_adv       (active),
    .o_h         (h_cnt),
    .o_v         (v_cnt),
    .o_h_last    (h_last),
    .o_v_last    (v_last),
    .o_frame_last(frame_last)
  );

  // Dropping i_en only takes effect at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (frame_last) state_d = i_en ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_eff   = ((h_cnt == '0) && (v_cnt == '0)) ? pat_sel_e'(i_pat_sel) : pat_q;
    pat_d     = active ? pat_eff : pat_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (active) begin
      if (h_last) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (int'(bar_cnt_q) == BAR_W - 1) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: timing decode and pixel value for the current raster position.
  always_comb begin
    logic                  de_c, hs_c, vs_c, done_c;
    logic [DATA_WIDTH-1:0] y_c, u_c, v_c, x_dw, l_dw;
    x_dw   = DATA_WIDTH'(h_cnt);
    l_dw   = DATA_WIDTH'(v_cnt);
    de_c   = active && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs_c   = active && (int'(h_cnt) >= H_ACTIVE + H_FP)
                    && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    vs_c   = active && (int'(v_cnt) >= V_ACTIVE + V_FP)
                    && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
    done_c = active && h_last && v_last;
    y_c    = '0;
    u_c    = '0;
    v_c    = '0;
    if (de_c) begin
      case (pat_eff)
        PAT_RAMP: begin
          y_c = x_dw + l_dw;
          u_c = x_dw;
          v_c = l_dw;
        end
        PAT_BARS: begin
          y_c = DATA_WIDTH'(BAR_Y[bar_idx_q]) << (DATA_WIDTH - 8);
          u_c = MID;
          v_c = MID;
        end
        PAT_CHECKER: begin
          y_c = (h_cnt[3] ^ v_cnt[3]) ? '1 : '0;
          u_c = MID;
          v_c = MID;
        end
        default: begin
          y_c = i_solid_y;
          u_c = i_solid_u;
          v_c = i_solid_v;
        end
      endcase
    end
    s1_d = {vs_c, hs_c, de_c, done_c, y_c, u_c, v_c};
  end

  assign frame_cnt_d = frame_cnt_q + {15'd0, s1_q[PW-4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= PAT_RAMP;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      s1_q        <= '0;
      out_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      s1_q        <= s1_d;
      out_q       <= s1_q;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_vs         = out_q[PW-1];
  assign o_hs         = out_q[PW-2];
  assign o_de         = out_q[PW-3];
  assign o_frame_done = out_q[PW-4];
  assign o_y          = out_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign o_u          = out_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign o_v          = out_q[DATA_WIDTH-1:0];
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: doc/filter_pattern_gen.md
# filter_pattern_gen

Synthetic video source for the image-filter datapath. It generates raster timing (`vs`/`hs`/`de`) and YUV test patterns, and sits directly upstream of the 5x5 filter top, driving its `i_vs`/`i_hs`/`i_de`/`i_y`/`i_u`/`i_v`. It lets the filter be exercised in simulation and on board without an external video source, with frame-exact, reproducible stimulus.

## Interface
- `DATA_WIDTH`, 8: pixel component width.
- `H_ACTIVE`, 64: active pixels per line. Must be a multiple of 8 and ≤ 4096.
- `H_FP` / `H_SYNC` / `H_BP`, 4 / 4 / 8: horizontal front porch, sync and back porch, in cycles.
- `V_ACTIVE`, 48: active lines per frame.
- `V_FP` / `V_SYNC` / `V_BP`, 2 / 2 / 2: vertical front porch, sync and back porch, in lines.
- `clk`  in  1  the block's one clock. All logic is on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `i_en`  in  1  run request (level).
- `i_pat_sel`  in  2  pattern select: 0 ramp, 1 colour bars, 2 checkerboard, 3 solid.
- `i_solid_y` / `i_solid_u` / `i_solid_v`  in  DATA_WIDTH each  solid-pattern values.
- `o_vs` / `o_hs` / `o_de`  out  1 each  timing outputs, all active-high.
- `o_y` / `o_u` / `o_v`  out  DATA_WIDTH each  pixel components.
- `o_frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `o_frame_cnt`  out  16  number of completed frames.

## Operation
- **Frame geometry**
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- **Counters**
  - `h` runs 0..H_TOTAL-1.
  - `v` increments when `h` wraps, and itself wraps at V_TOTAL-1.
- **Timing outputs**
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. hs toggles on every line, including blanking lines.
  - vs = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, asserted for whole lines.
- **FSM**
  - IDLE: counters held at 0, all outputs 0. Goes to RUN when `i_en`=1.
  - RUN: free-running. If `i_en`=0 at any point, goes to DRAIN.
  - DRAIN: completes the current frame, then goes to IDLE. If `i_en` returns high during DRAIN, the next state after the frame's last cycle is RUN instead (no gap).
- **Pattern select**
  - `i_pat_sel` is latched at h=0, v=0 of every frame and held for that whole frame.
- **Patterns** (x = h, l = v, values taken modulo 2^DATA_WIDTH)
  - Ramp: y = x + l, u = x, v = l.
  - Bars: 8 bars, each H_ACTIVE/8 pixels wide. A bar index counter advances every H_ACTIVE/8 pixels (no divider). y = BAR_Y[idx], u = v = 128.
  - Checkerboard: 8x8 cells. y = (x[3]^l[3]) ? 2^DATA_WIDTH-1 : 0. u = v = 128.
  - Solid: y/u/v = `i_solid_*`.
- **Blanking**: when de=0, y/u/v = 0.
- **Frame end**: `o_frame_done` pulses on the output cycle for h=H_TOTAL-1, v=V_TOTAL-1. `o_frame_cnt` increments on the same edge and wraps 0xFFFF→0.

## Timing
- **Reset values**: all outputs 0, state IDLE, h = v = 0, `o_frame_cnt` = 0.
- **Reset mid-frame**: all outputs are 0 on the cycle after `rst` is sampled high. There is no partial-frame completion. With `i_en` high, generation restarts from h=0, v=0 after `rst` deasserts.
- **Output registering**: all outputs are registered and mutually aligned.
- **Start latency**:
  - `i_en` sampled high in IDLE at edge t → RUN with h=0 at t+1.
  - First `o_de`=1 (pixel x=0, l=0) at t+2.
- **Frame length**: exactly H_TOTAL × V_TOTAL cycles. With defaults: H_TOTAL=80, V_TOTAL=54, 4320 cycles per frame.
- **Frame continuity**: there are no idle cycles between consecutive frames while running.

## Structure
- **Package `filter_pkg`**:
  - pattern-select enum (RAMP, BARS, CHECKER, SOLID);
  - 8-entry `BAR_Y` table: 235, 210, 170, 145, 106, 81, 41, 16 (for DATA_WIDTH=8);
  - FSM state enum;
  - default timing constants.
- **Sub-module `filter_hv_counter`**: h/v counters with wrap logic and terminal flags `h_last`, `v_last`, `frame_last`. `filter_pattern_gen` contains the FSM, pattern logic and output registers.

## Test plan
- **Reset**: `rst`=1 for 3 cycles with `i_en`=1 → all outputs 0 and `o_frame_cnt`=0 during reset; first `o_de` appears 2 cycles after `rst` falls.
- **Default timing, ramp pattern**:
  - 3072 de cycles per frame; 64 de cycles per line.
  - `o_hs` rises 68 cycles after each `de` rise and stays high for 4 cycles.
  - `o_vs` is high for 160 consecutive cycles starting at line 50, h=0.
  - `o_frame_done` period is 4320.
- **Ramp values**: line 3, pixel 10 → y=13, u=10, v=3. Line 47, pixel 63 → y=110.
- **Bars**: pixels 0–7 → y=235; pixels 56–63 → y=16; u = v = 128 on every active pixel.
- **Pattern latch**: switch `i_pat_sel` 0→3 at line 20 with solid values (50, 60, 70) → rest of the current frame stays ramp; next frame is all (50, 60, 70).
- **Stop and restart**:
  - `i_en`=0 at line 10 → frame completes, `o_frame_done` pulses, then outputs stay 0.
  - Re-assert `i_en` → `o_de` rises 2 cycles later with x=0.
  - `o_frame_cnt` has incremented by 1.
